// File: rtl/muldiv_unit_if.sv
// Handshake and operand bus between the EX stage and the iterative multiply/divide unit.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            kill;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output start, op, rs1, rs2, kill, input busy, done, result);
    modport slave  (input start, op, rs1, rs2, kill, output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: shift-add multiplier and restoring divider on one XLEN-cycle datapath.
// Optional MULDIV_FAST_MUL_EN replaces the iterative multiply with a combinational multiplier.
//
// state  | meaning
// S_IDLE | waiting for start
// S_CALC | one iteration per cycle; a single pass-through cycle for precomputed results
// S_FIN  | result registered, done pulse, can accept a new start
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   pre_q, pre_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic              skip_q, skip_d;

    logic              accept;
    logic              rs1_signed, rs2_signed, sa, sb;
    logic [XLEN-1:0]   abs1, abs2;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   pre_val;
    logic [XLEN:0]     mul_sum, div_trial;
    logic [2*XLEN-1:0] mul_nxt, div_nxt, step_nxt;
`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fast_a, fast_b;
    logic signed [2*XLEN+1:0] fast_prod;
`endif

    function automatic logic [XLEN-1:0] finalize(
        input logic [2*XLEN-1:0] acc,
        input logic [2:0]        op,
        input logic              neg,
        input logic              skip,
        input logic [XLEN-1:0]   pre
    );
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quot, rem;
        prod = neg ? -acc : acc;
        quot = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (skip && op[2]) return pre;
        case (op)
            3'b000:                 return prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: return prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         return quot;
            default:                return rem;
        endcase
    endfunction

    always_comb begin
        accept     = bus.start && !bus.kill && (state_q == S_IDLE || state_q == S_FIN);
        rs1_signed = (bus.op == 3'b001) || (bus.op == 3'b010) || (bus.op == 3'b100) || (bus.op == 3'b110);
        rs2_signed = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
        sa         = rs1_signed && bus.rs1[XLEN-1];
        sb         = rs2_signed && bus.rs2[XLEN-1];
        abs1       = sa ? -bus.rs1 : bus.rs1;
        abs2       = sb ? -bus.rs2 : bus.rs2;
        div_zero   = (bus.rs2 == '0);
        div_ovf    = !bus.op[0] && (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2 == '1);
        special    = bus.op[2] && (div_zero || div_ovf);
        if (div_zero) pre_val = bus.op[1] ? bus.rs1 : '1;
        else          pre_val = bus.op[1] ? '0 : bus.rs1;
    end

    // Carry out of the add lands in the top bit after the right shift.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (b_q[0] ? {1'b0, a_q} : '0);
        mul_nxt   = {mul_sum, acc_q[XLEN-1:1]};
        div_trial = {acc_q[2*XLEN-1], acc_q[2*XLEN-2:XLEN-1]} - {1'b0, a_q};
        div_nxt   = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                    : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        step_nxt  = op_q[2] ? div_nxt : mul_nxt;
    end

`ifdef MULDIV_FAST_MUL_EN
    always_comb begin
        fast_a    = {rs1_signed && bus.rs1[XLEN-1], bus.rs1};
        fast_b    = {rs2_signed && bus.rs2[XLEN-1], bus.rs2};
        fast_prod = fast_a * fast_b;
    end
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        pre_d    = pre_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        skip_d   = skip_q;
        result_d = result_q;

        case (state_q)
            S_CALC: begin
                if (skip_q) begin
                    state_d  = S_FIN;
                    result_d = finalize(acc_q, op_q, neg_q, skip_q, pre_q);
                end else begin
                    acc_d = step_nxt;
                    b_d   = b_q >> 1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN-1)) begin
                        state_d  = S_FIN;
                        result_d = finalize(step_nxt, op_q, neg_q, 1'b0, pre_q);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                if (accept) begin
                    state_d = S_CALC;
                    op_d    = bus.op;
                    a_d     = bus.op[2] ? abs2 : abs1;
                    b_d     = abs2;
                    acc_d   = bus.op[2] ? {{XLEN{1'b0}}, abs1} : '0;
                    cnt_d   = '0;
                    neg_d   = (bus.op[2] && bus.op[1]) ? sa : (sa ^ sb);
                    skip_d  = special;
                    pre_d   = pre_val;
`ifdef MULDIV_FAST_MUL_EN
                    if (!bus.op[2]) begin
                        acc_d  = fast_prod[2*XLEN-1:0];
                        neg_d  = 1'b0;
                        skip_d = 1'b1;
                    end
`endif
                end
            end
        endcase

        if (bus.kill) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            pre_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            skip_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            pre_q    <= pre_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            skip_q   <= skip_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = (state_q == S_CALC);
    assign bus.done   = (state_q == S_FIN);
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at XLEN=32 and XLEN=16.
module tb_muldiv_unit;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;
    localparam int SPC_LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    logic [31:0] exp_q[$];
    int          lat_q[$];

    muldiv_unit_if #(.XLEN(32)) bus32();
    muldiv_unit_if #(.XLEN(16)) bus16();

    muldiv_unit #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    muldiv_unit #(.XLEN(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    always #5 clk = ~clk;

    // Called on the negedge right after the accepting edge; returns on the negedge inside DONE.
    task automatic wait_done32(output int lat, output int busy_n, output bit ok);
        lat = 1; busy_n = 0; ok = 1'b1;
        while (bus32.done !== 1'b1) begin
            if (bus32.busy === 1'b1) busy_n++;
            if (lat >= 200) begin ok = 1'b0; break; end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat, busy_n;
        bit ok;
        logic [31:0] e;
        int el;
        exp_q.push_back(exp);
        lat_q.push_back(exp_lat);
        @(negedge clk);
        bus32.start = 1'b1; bus32.op = op; bus32.rs1 = a; bus32.rs2 = b;
        @(negedge clk);
        bus32.start = 1'b0; bus32.op = 3'($urandom_range(0, 7));
        bus32.rs1 = $urandom; bus32.rs2 = $urandom;
        wait_done32(lat, busy_n, ok);
        e = exp_q.pop_front();
        el = lat_q.pop_front();
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL %s timeout: no done within %0d cycles", name, lat);
            return;
        end
        if (bus32.result !== e) begin
            tests_failed++;
            $display("FAIL %s result: got %h expected %h", name, bus32.result, e);
        end
        tests_run++;
        if (lat != el) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, el);
        end
        tests_run++;
        if (busy_n != el - 1 || bus32.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s busy: got %0d cycles (busy in done=%b) expected %0d", name, busy_n, bus32.busy, el - 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus32.busy !== 1'b0 || bus32.done !== 1'b0 || bus32.result !== 32'h0 ||
            bus16.busy !== 1'b0 || bus16.done !== 1'b0 || bus16.result !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset: busy=%b done=%b result=%h (16: %b %b %h) expected 0 0 0",
                     bus32.busy, bus32.done, bus32.result, bus16.busy, bus16.done, bus16.result);
        end
        rst = 1'b0;
    endtask

    task automatic test_mul();
        do_op("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        do_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
        do_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        do_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
        do_op("mulh_mixed", 3'b001, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, MUL_LAT);
    endtask

    task automatic test_div();
        do_op("div",  3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT);
        do_op("rem",  3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT);
        do_op("divu", 3'b101, 32'd100, 32'd7, 32'd14, DIV_LAT);
        do_op("remu", 3'b111, 32'd100, 32'd7, 32'd2, DIV_LAT);
        do_op("divu_big", 3'b101, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, DIV_LAT);
    endtask

    task automatic test_special();
        do_op("divu_zero", 3'b101, 32'h1234, 32'h0, 32'hFFFF_FFFF, SPC_LAT);
        do_op("rem_zero",  3'b110, 32'h1234, 32'h0, 32'h0000_1234, SPC_LAT);
        do_op("div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT);
        do_op("rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, SPC_LAT);
    endtask

    task automatic test_kill();
        logic [31:0] prev;
        bit seen_done;
        do_op("kill_pre", 3'b101, 32'd1000, 32'd10, 32'd100, DIV_LAT);
        prev = 32'd100;
        @(negedge clk);
        bus32.start = 1'b1; bus32.op = 3'b101; bus32.rs1 = 32'd77; bus32.rs2 = 32'd5;
        @(negedge clk);
        bus32.start = 1'b0;
        repeat (9) @(negedge clk);
        bus32.kill = 1'b1;
        @(negedge clk);
        bus32.kill = 1'b0;
        tests_run++;
        if (bus32.busy !== 1'b0 || bus32.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL kill_busy: busy=%b done=%b expected 0 0", bus32.busy, bus32.done);
        end
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus32.done === 1'b1) seen_done = 1'b1;
        end
        tests_run++;
        if (seen_done || bus32.result !== prev) begin
            tests_failed++;
            $display("FAIL kill_result: done seen=%b result=%h expected no done, %h", seen_done, bus32.result, prev);
        end
        bus32.start = 1'b1; bus32.kill = 1'b1; bus32.op = 3'b000; bus32.rs1 = 32'd3; bus32.rs2 = 32'd3;
        @(negedge clk);
        bus32.start = 1'b0; bus32.kill = 1'b0;
        tests_run++;
        if (bus32.busy !== 1'b0 || bus32.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL kill_start: busy=%b done=%b expected 0 0", bus32.busy, bus32.done);
        end
        do_op("after_kill", 3'b000, 32'd6, 32'd9, 32'd54, MUL_LAT);
    endtask

    task automatic test_back_to_back();
        int lat, busy_n;
        bit ok;
        logic [31:0] e;
        exp_q.push_back(32'd14);
        exp_q.push_back(32'd2);
        @(negedge clk);
        bus32.start = 1'b1; bus32.op = 3'b101; bus32.rs1 = 32'd100; bus32.rs2 = 32'd7;
        @(negedge clk);
        bus32.start = 1'b0;
        wait_done32(lat, busy_n, ok);
        e = exp_q.pop_front();
        tests_run++;
        if (!ok || bus32.result !== e) begin
            tests_failed++;
            $display("FAIL b2b_first: ok=%b result=%h expected %h", ok, bus32.result, e);
        end
        bus32.start = 1'b1; bus32.op = 3'b111; bus32.rs1 = 32'd100; bus32.rs2 = 32'd7;
        @(negedge clk);
        bus32.start = 1'b0;
        tests_run++;
        if (bus32.busy !== 1'b1 || bus32.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_accept: busy=%b done=%b expected 1 0", bus32.busy, bus32.done);
        end
        wait_done32(lat, busy_n, ok);
        e = exp_q.pop_front();
        tests_run++;
        if (!ok || bus32.result !== e || lat != DIV_LAT) begin
            tests_failed++;
            $display("FAIL b2b_second: ok=%b result=%h lat=%0d expected %h lat %0d", ok, bus32.result, lat, e, DIV_LAT);
        end
    endtask

    task automatic test_rst_mid();
        @(negedge clk);
        bus32.start = 1'b1; bus32.op = 3'b101; bus32.rs1 = 32'd500; bus32.rs2 = 32'd3;
        @(negedge clk);
        bus32.start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if (bus32.busy !== 1'b0 || bus32.done !== 1'b0 || bus32.result !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_mid: busy=%b done=%b result=%h expected 0 0 0", bus32.busy, bus32.done, bus32.result);
        end
    endtask

    task automatic test_xlen16(input string name, input logic [2:0] op, input logic [15:0] a,
                               input logic [15:0] b, input logic [15:0] exp, input int exp_lat);
        int lat;
        logic [31:0] e;
        exp_q.push_back({16'h0, exp});
        @(negedge clk);
        bus16.start = 1'b1; bus16.op = op; bus16.rs1 = a; bus16.rs2 = b;
        @(negedge clk);
        bus16.start = 1'b0; bus16.rs1 = 16'($urandom); bus16.rs2 = 16'($urandom);
        lat = 1;
        while (bus16.done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        e = exp_q.pop_front();
        tests_run++;
        if (bus16.done !== 1'b1 || bus16.result !== e[15:0] || lat != exp_lat) begin
            tests_failed++;
            $display("FAIL %s: done=%b result=%h lat=%0d expected %h lat %0d", name, bus16.done, bus16.result, lat, e[15:0], exp_lat);
        end
    endtask

    initial begin
        bus32.start = 1'b0; bus32.kill = 1'b0; bus32.op = '0; bus32.rs1 = '0; bus32.rs2 = '0;
        bus16.start = 1'b0; bus16.kill = 1'b0; bus16.op = '0; bus16.rs1 = '0; bus16.rs2 = '0;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_kill();
        test_back_to_back();
        test_rst_mid();
`ifdef MULDIV_FAST_MUL_EN
        test_xlen16("x16_mulhu", 3'b011, 16'hFFFF, 16'hFFFF, 16'hFFFE, 2);
`else
        test_xlen16("x16_mulhu", 3'b011, 16'hFFFF, 16'hFFFF, 16'hFFFE, 17);
`endif
        test_xlen16("x16_divu", 3'b101, 16'hFFFF, 16'd3, 16'h5555, 17);
        test_xlen16("x16_rem",  3'b110, 16'hFFF9, 16'd2, 16'hFFFF, 17);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
